// File: rtl/mul_div_unit_pkg.sv
// mul_div_unit_pkg: op encodings, FSM states and counter sizing shared by the multiply/divide unit
package mul_div_unit_pkg;
  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_t;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, FIX, DONE} state_t;
  function automatic int cnt_w(input int bus);
    return $clog2(bus);
  endfunction
endpackage

// File: rtl/mul_div_unit_sumador.sv
// sumador_parametrizable: bus-wide adder with carry in/out, used for both shift-add and trial subtraction
//   i_a, i_b : addends          i_cin  : carry in (1 with ~b gives a-b)
//   o_s      : sum              o_cout : carry out (no-borrow flag when subtracting)
module sumador_parametrizable #(
  parameter int bus = 8
) (
  input  logic [bus-1:0] i_a,
  input  logic [bus-1:0] i_b,
  input  logic           i_cin,
  output logic [bus-1:0] o_s,
  output logic           o_cout
);
  assign {o_cout, o_s} = {1'b0, i_a} + {1'b0, i_b} + {{bus{1'b0}}, i_cin};
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO result registers
//   clk, rst      : clock, asynchronous active-high reset
//   i_start       : request, sampled only in IDLE
//   i_op          : 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   i_a, i_b      : multiplicand/dividend, multiplier/divisor
//   o_busy        : operation in flight
//   o_done        : one-cycle pulse, o_hi/o_lo valid
//   o_hi, o_lo    : product halves, or remainder/quotient
//   o_dz          : last division had a zero divisor
//   MULDIV_EARLY_DZ_EN : when defined, a zero-divisor divide skips RUN/FIX
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int bus = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_start,
  input  logic [1:0]     i_op,
  input  logic [bus-1:0] i_a,
  input  logic [bus-1:0] i_b,
  output logic           o_busy,
  output logic           o_done,
  output logic [bus-1:0] o_hi,
  output logic [bus-1:0] o_lo,
  output logic           o_dz
);
  localparam int CW = cnt_w(bus);
  state_t             r_state;
  op_t                r_op;
  logic [bus-1:0]     r_a, r_b, r_mcand, r_acc_hi, r_acc_lo, r_hi, r_lo;
  logic [CW-1:0]      r_cnt;
  logic               r_sign_q, r_sign_r, r_dz, r_busy, r_done;
  logic               w_div, w_sgn, w_dz, w_cout, w_ok;
  logic [bus-1:0]     w_mag_a, w_mag_b, w_rem_sh, w_add_a, w_add_b, w_sum, w_nxt_hi, w_nxt_lo;
  logic [2*bus-1:0]   w_prod_neg;
  assign w_div      = (r_op == OP_DIVU) || (r_op == OP_DIV);
  assign w_sgn      = (r_op == OP_MULT) || (r_op == OP_DIV);
  assign w_dz       = w_div && (r_b == '0);
  assign w_mag_a    = (w_sgn && r_a[bus-1]) ? -r_a : r_a;
  assign w_mag_b    = (w_sgn && r_b[bus-1]) ? -r_b : r_b;
  // remainder shifted left with the next dividend bit; the bit shifted out is kept in w_ok
  assign w_rem_sh   = {r_acc_hi[bus-2:0], r_acc_lo[bus-1]};
  assign w_add_a    = w_div ? w_rem_sh : r_acc_hi;
  assign w_add_b    = w_div ? ~r_mcand : (r_acc_lo[0] ? r_mcand : '0);
  assign w_ok       = r_acc_hi[bus-1] | w_cout;
  assign w_nxt_hi   = w_div ? (w_ok ? w_sum : w_rem_sh) : {w_cout, w_sum[bus-1:1]};
  assign w_nxt_lo   = w_div ? {r_acc_lo[bus-2:0], w_ok} : {w_sum[0], r_acc_lo[bus-1:1]};
  assign w_prod_neg = -{r_acc_hi, r_acc_lo};
  sumador_parametrizable #(.bus(bus)) u_add (
    .i_a(w_add_a), .i_b(w_add_b), .i_cin(w_div), .o_s(w_sum), .o_cout(w_cout)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state  <= IDLE;
      r_op     <= OP_MULTU;
      r_a      <= '0;
      r_b      <= '0;
      r_mcand  <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_cnt    <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_dz     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_state <= LOAD;
            r_op    <= op_t'(i_op);
            r_a     <= i_a;
            r_b     <= i_b;
            r_dz    <= 1'b0;
          end
        end
        LOAD: begin
          r_busy   <= 1'b1;
          r_dz     <= w_dz;
          r_sign_q <= w_sgn & (r_a[bus-1] ^ r_b[bus-1]);
          r_sign_r <= w_sgn & r_a[bus-1];
          r_mcand  <= w_div ? w_mag_b : w_mag_a;
          r_acc_hi <= '0;
          r_acc_lo <= w_div ? w_mag_a : w_mag_b;
          r_cnt    <= CW'(bus - 1);
`ifdef MULDIV_EARLY_DZ_EN
          r_state  <= w_dz ? DONE : RUN;
`else
          r_state  <= RUN;
`endif
        end
        RUN: begin
          r_acc_hi <= w_nxt_hi;
          r_acc_lo <= w_nxt_lo;
          r_cnt    <= r_cnt - 1'b1;
          if (r_cnt == '0) r_state <= FIX;
        end
        FIX: begin
          if (!w_div) {r_acc_hi, r_acc_lo} <= r_sign_q ? w_prod_neg : {r_acc_hi, r_acc_lo};
          else begin
            r_acc_lo <= r_sign_q ? -r_acc_lo : r_acc_lo;
            r_acc_hi <= r_sign_r ? -r_acc_hi : r_acc_hi;
          end
          r_state <= DONE;
        end
        DONE: begin
          r_hi    <= r_dz ? r_a : r_acc_hi;
          r_lo    <= r_dz ? '1 : r_acc_lo;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;
  assign o_dz   = r_dz;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: randomized scoreboard bench for mul_div_unit against an arithmetic reference model
module tb_mul_div_unit;
  localparam int BUS = 8;
`ifdef MULDIV_EARLY_DZ_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  typedef struct {
    logic [BUS-1:0] hi;
    logic [BUS-1:0] lo;
    logic           dz;
  } exp_t;
  logic           clk = 1'b0, rst = 1'b1, i_start = 1'b0;
  logic [1:0]     i_op = '0;
  logic [BUS-1:0] i_a = '0, i_b = '0;
  logic           o_busy, o_done, o_dz;
  logic [BUS-1:0] o_hi, o_lo;
  exp_t           q_exp[$];
  int             checks = 0, errors = 0;
  mul_div_unit #(.bus(BUS)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_op(i_op), .i_a(i_a), .i_b(i_b),
    .o_busy(o_busy), .o_done(o_done), .o_hi(o_hi), .o_lo(o_lo), .o_dz(o_dz)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic void model(input logic [1:0] op, input logic [BUS-1:0] a, input logic [BUS-1:0] b,
                                output logic [BUS-1:0] hi, output logic [BUS-1:0] lo, output logic dz);
    longint x, y, p, q, r;
    x  = op[0] ? longint'($signed(a)) : longint'(a);
    y  = op[0] ? longint'($signed(b)) : longint'(b);
    dz = 1'b0;
    if (!op[1]) begin
      p  = x * y;
      hi = p[2*BUS-1:BUS];
      lo = p[BUS-1:0];
    end else if (b == '0) begin
      hi = a;
      lo = '1;
      dz = 1'b1;
    end else begin
      q  = x / y;
      r  = x % y;
      hi = r[BUS-1:0];
      lo = q[BUS-1:0];
    end
  endfunction
  always @(negedge clk)
    if (o_done) begin
      if (q_exp.size() == 0) chk("unexpected_done", 32'(o_done), 32'd0);
      else begin
        exp_t e;
        e = q_exp.pop_front();
        checks++;
        if (o_hi !== e.hi || o_lo !== e.lo || o_dz !== e.dz) begin
          errors++;
          $display("FAIL result: got hi=%h lo=%h dz=%b expected hi=%h lo=%h dz=%b",
                   o_hi, o_lo, o_dz, e.hi, e.lo, e.dz);
        end
      end
    end
  task automatic run_op(input logic [1:0] op, input logic [BUS-1:0] a, input logic [BUS-1:0] b, input bit noise);
    exp_t           e;
    int             lat, n;
    bit             busy_ok, hold_ok;
    logic [BUS-1:0] prev_hi, prev_lo;
    model(op, a, b, e.hi, e.lo, e.dz);
    q_exp.push_back(e);
    lat = (op[1] && b == '0 && EARLY) ? 2 : BUS + 3;
    @(negedge clk);
    i_start = 1'b1; i_op = op; i_a = a; i_b = b;
    prev_hi = o_hi; prev_lo = o_lo;
    @(posedge clk);
    #1 i_start = 1'b0;
    n = 0; busy_ok = 1'b1; hold_ok = 1'b1;
    while (!o_done && n < 4 * BUS + 20) begin
      if (noise && (n + 1 == 3 || n + 1 == lat)) begin
        i_start = 1'b1; i_op = 2'($urandom); i_a = BUS'($urandom); i_b = BUS'($urandom);
      end
      @(posedge clk);
      #1 i_start = 1'b0;
      n++;
      if (!o_done && !o_busy) busy_ok = 1'b0;
      if (!o_done && (o_hi !== prev_hi || o_lo !== prev_lo)) hold_ok = 1'b0;
    end
    chk("latency", 32'(n), 32'(lat));
    chk("busy_during_op", 32'(busy_ok), 32'd1);
    chk("hilo_hold", 32'(hold_ok), 32'd1);
    chk("busy_at_done", 32'(o_busy), 32'd0);
    @(posedge clk);
    #1;
    chk("done_single_pulse", 32'(o_done), 32'd0);
    chk("idle_after_done", 32'(o_busy), 32'd0);
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(o_busy), 32'd0);
    chk("reset_done", 32'(o_done), 32'd0);
    chk("reset_hilo", 32'({o_hi, o_lo}), 32'd0);
    chk("reset_dz", 32'(o_dz), 32'd0);
    @(negedge clk) rst = 1'b0;
    run_op(2'b00, 8'hFF, 8'hFF, 1'b0);
    run_op(2'b01, 8'hFD, 8'h05, 1'b0);
    run_op(2'b01, 8'h80, 8'h80, 1'b0);
    run_op(2'b10, 8'd200, 8'd7, 1'b0);
    run_op(2'b11, 8'hF9, 8'h02, 1'b0);
    run_op(2'b11, 8'h80, 8'hFF, 1'b0);
    run_op(2'b10, 8'h2A, 8'h00, 1'b0);
    run_op(2'b11, 8'h85, 8'h00, 1'b0);
    run_op(2'b00, 8'h03, 8'h04, 1'b1);
    run_op(2'b10, 8'd200, 8'd7, 1'b0);
    @(negedge clk);
    i_start = 1'b1; i_op = 2'b10; i_a = 8'd100; i_b = 8'd3;
    @(posedge clk);
    #1 i_start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(o_busy), 32'd0);
    chk("abort_hilo", 32'({o_hi, o_lo}), 32'd0);
    chk("abort_dz", 32'(o_dz), 32'd0);
    repeat (3) @(posedge clk);
    #1 chk("abort_no_done", 32'(o_done), 32'd0);
    @(negedge clk) rst = 1'b0;
    run_op(2'b10, 8'd100, 8'd3, 1'b0);
    for (int i = 0; i < 40; i++) begin
      logic [1:0]     op;
      logic [BUS-1:0] a, b;
      op = 2'($urandom_range(0, 3));
      a  = BUS'($urandom);
      b  = ($urandom_range(0, 7) == 0) ? '0 : BUS'($urandom);
      if ($urandom_range(0, 9) == 0) begin a = 8'h80; b = 8'hFF; end
      run_op(op, a, b, 1'b0);
    end
    repeat (3) @(posedge clk);
    #1 chk("scoreboard_empty", 32'(q_exp.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Multi-cycle multiply/divide unit for the MIPS datapath, the sequential successor to the combinational ALU.
- Executes MULT, MULTU, DIV and DIVU on bus-wide operands using iterative shift-add multiplication and restoring division.
- Results are held in HI/LO registers and read by MFHI/MFLO.
- The control unit stalls on busy.

Parameters:
- bus, 8, operand width in bits; HI and LO are each bus wide; legal values are 4 and above.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- a  input  bus  multiplicand or dividend.
- b  input  bus  multiplier or divisor.
- busy  output  1  high from the edge after start is accepted until done.
- done  output  1  single-cycle pulse; hi/lo are valid in this cycle.
- hi  output  bus  product upper half, or remainder.
- lo  output  bus  product lower half, or quotient.
- dz  output  1  last division had a zero divisor; cleared at the next accepted start.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, busy=0, done=0, hi=0, lo=0, dz=0, counter=0. Asserting rst mid-operation aborts immediately; no partial result reaches hi/lo.
- States:
  - IDLE -> LOAD when start=1.
  - LOAD -> RUN.
  - RUN loops for bus cycles -> FIX.
  - FIX -> DONE.
  - DONE -> IDLE.
- LOAD:
  - Latch op and |a|, |b|, taking the magnitude only for signed ops.
  - Record sign_q = a[msb]^b[msb] and sign_r = a[msb].
  - Clear the accumulator; set counter = bus-1; dz = (op[1] && b==0).
- RUN, multiply: if the multiplier LSB is 1, acc_hi += multiplicand with carry; shift {carry,acc_hi,acc_lo} right by 1; counter decrements.
- RUN, divide: shift {rem,quot} left by 1; trial = rem - divisor. If trial is non-negative: rem=trial, quot LSB=1; otherwise restore rem.
- FIX: for signed ops, negate the 2*bus product if sign_q=1; negate the quotient if sign_q=1; negate the remainder if sign_r=1.
- DONE:
  - hi/lo written; done=1 for exactly one cycle; busy=0 on the following edge.
  - Latency: start accepted at edge N, done high after edge N+bus+3, so new results are visible bus+3 cycles after the start edge.
- start while busy or in DONE is ignored and not queued. start asserted in the cycle after DONE (IDLE) is accepted.
- hi/lo hold their previous values throughout an operation.
- Division by zero: hi=a (original dividend), lo = all ones, dz=1. Full latency unless the optional feature is enabled. Signedness of op is ignored for the result.
- Signed overflow (DIV of most-negative by -1): lo = most-negative (wraps), hi=0, dz=0.
- MULT sign rules: operands in two's complement, 2*bus-bit exact product, no overflow possible.
- Remainder always takes the dividend's sign; the quotient truncates toward zero.

Optional Feature:
- MULDIV_EARLY_DZ_EN defined:
  - A divide with b==0 goes LOAD -> DONE directly, so done is high after edge N+2.
  - Results are the same as the div-by-zero rule; RUN and FIX are skipped.
- Macro undefined: a zero divisor takes the full bus+3 latency, and its results come from the explicit div-by-zero rule, not from the iteration.

Decomposition:
- Shared package: op encodings (OP_MULTU, OP_MULT, OP_DIVU, OP_DIV) and state encoding (IDLE, LOAD, RUN, FIX, DONE).
- Counter width constant = clog2(bus).
- Sub-module: sumador_parametrizable #(bus) instance for the iteration add/subtract, with subtract as add of the inverted divisor plus cin=1 and cout as the "no borrow" indicator.
- Two's-complement negation is done inline.

Test Plan (bus=8):
- MULTU a=0xFF b=0xFF -> done after 11 cycles, hi=0xFE lo=0x01, dz=0; busy high for cycles 1-10.
- MULT a=0xFD (-3) b=0x05 -> hi=0xFF lo=0xF1 (-15). MULT 0x80*0x80 -> hi=0x40 lo=0x00.
- DIVU a=200 b=7 -> lo=0x1C hi=0x04. DIV a=0xF9 (-7) b=0x02 -> lo=0xFD hi=0xFF. DIV 0x80/0xFF -> lo=0x80 hi=0x00.
- DIVU a=0x2A b=0x00 -> hi=0x2A lo=0xFF dz=1; done after 11 cycles, or after 2 with MULDIV_EARLY_DZ_EN.
- Start MULTU 3*4, pulse start with a new op at cycles 3 and 11 (DONE) -> both ignored; hi=0x00 lo=0x0C; next start in IDLE accepted.
- Start DIVU, assert rst at cycle 5 -> all outputs 0 immediately; no done pulse; a fresh start after release completes normally.
